// File: rtl/isp_bnr_pkg.sv
// Shared definitions for the Bayer noise-reduction control path: register map, FSM encoding,
// and the NR level range shared with the BNR datapath.
package isp_bnr_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_TARGET = 2'd1;
  localparam logic [1:0] ADDR_RAMP   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int unsigned NR_LEVEL_MAX = 4;

  typedef enum logic [1:0] {
    StDisabled = 2'd0,
    StArmed    = 2'd1,
    StRun      = 2'd2
  } bnr_state_e;

  function automatic logic [3:0] clamp_level(input logic [3:0] lvl, input logic [3:0] max_lvl);
    return (lvl > max_lvl) ? max_lvl : lvl;
  endfunction

endpackage

// File: rtl/isp_sync_edge.sv
// Frame-start and line-end strobes from the sensor sync signals. Both strobes are combinational
// from the current input and a one-clock delayed copy.
module isp_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic vsync_i,
  input  logic href_i,
  output logic fs_o,
  output logic le_o
);

  logic vsync_q, href_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      href_q  <= href_i;
    end
  end

  assign fs_o = vsync_i & ~vsync_q;
  assign le_o = href_q & ~href_i;

endmodule

// File: rtl/isp_bnr_ctrl.sv
// Frame-synchronous sequencer for the BNR nr_level input: shadowed config registers committed at
// frame start, manual or auto-ramped level, and top-of-frame edge-line suppression.
module isp_bnr_ctrl
  import isp_bnr_pkg::*;
#(
  parameter int unsigned EDGE_LINES = 2,
  parameter int unsigned MAX_LEVEL  = NR_LEVEL_MAX,
  parameter int unsigned FCNT_BITS  = 16
) (
  input  logic                 pclk,
  input  logic                 rst,
  input  logic                 cfg_valid,
  input  logic                 cfg_write,
  input  logic [1:0]           cfg_addr,
  input  logic [7:0]           cfg_wdata,
  output logic                 cfg_ready,
  output logic [7:0]           cfg_rdata,
  output logic                 cfg_rvalid,
  input  logic                 in_href,
  input  logic                 in_vsync,
  output logic [3:0]           nr_level,
  output logic                 ramp_busy,
  output logic [FCNT_BITS-1:0] frame_cnt
);

  localparam int unsigned LcBits = (EDGE_LINES < 1) ? 1 : $clog2(EDGE_LINES + 1);
  localparam logic [LcBits-1:0] EdgeLines = LcBits'(EDGE_LINES);
  localparam logic [3:0] MaxLvl = 4'(MAX_LEVEL);

  logic fs, le;

  isp_sync_edge u_sync_edge (
    .clk_i   (pclk),
    .rst_i   (rst),
    .vsync_i (in_vsync),
    .href_i  (in_href),
    .fs_o    (fs),
    .le_o    (le)
  );

  // Shadow (software-visible) registers
  logic       en_sh_q, en_sh_d;
  logic       auto_sh_q, auto_sh_d;
  logic [3:0] tgt_sh_q, tgt_sh_d;
  logic [7:0] ramp_sh_q, ramp_sh_d;
  // Working set committed at frame start
  logic       cur_auto_q, cur_auto_d;
  logic [3:0] cur_tgt_q, cur_tgt_d;

  bnr_state_e           state_q, state_d;
  logic [3:0]           active_q, active_d;
  logic [7:0]           ramp_cnt_q, ramp_cnt_d;
  logic [LcBits-1:0]    line_cnt_q, line_cnt_d;
  logic [FCNT_BITS-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]           nr_level_q, nr_level_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;

  logic       wr_acc, rd_acc;
  logic [7:0] ivl_m1;
  logic [7:0] status;

  // Commit cycles refuse access so a write can never race the shadow-to-working copy.
  assign cfg_ready = rst | ~fs;
  assign wr_acc    = cfg_valid & cfg_ready & cfg_write;
  assign rd_acc    = cfg_valid & cfg_ready & ~cfg_write;

  assign ramp_busy = (state_q == StRun) & cur_auto_q & (active_q != cur_tgt_q);
  assign status    = {1'b0, ramp_busy, state_q, active_q};
  assign ivl_m1    = (ramp_sh_q == 8'd0) ? 8'd0 : ramp_sh_q - 8'd1;

  always_comb begin
    en_sh_d   = en_sh_q;
    auto_sh_d = auto_sh_q;
    tgt_sh_d  = tgt_sh_q;
    ramp_sh_d = ramp_sh_q;
    if (wr_acc) begin
      case (cfg_addr)
        ADDR_CTRL: begin
          en_sh_d   = cfg_wdata[0];
          auto_sh_d = cfg_wdata[1];
        end
        ADDR_TARGET: tgt_sh_d  = clamp_level(cfg_wdata[3:0], MaxLvl);
        ADDR_RAMP:   ramp_sh_d = cfg_wdata;
        default:     ;
      endcase
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = rd_acc;
    if (rd_acc) begin
      case (cfg_addr)
        ADDR_CTRL:   rdata_d = {6'd0, auto_sh_q, en_sh_q};
        ADDR_TARGET: rdata_d = {4'd0, tgt_sh_q};
        ADDR_RAMP:   rdata_d = ramp_sh_q;
        default:     rdata_d = status;
      endcase
    end
  end

  always_comb begin
    cur_auto_d = cur_auto_q;
    cur_tgt_d  = cur_tgt_q;
    if (fs) begin
      cur_auto_d = auto_sh_q;
      cur_tgt_d  = tgt_sh_q;
    end
  end

  always_comb begin
    line_cnt_d = line_cnt_q;
    if (fs) begin
      line_cnt_d = '0;
    end else if (le && (line_cnt_q < EdgeLines)) begin
      line_cnt_d = line_cnt_q + LcBits'(1);
    end
  end

  // Decisions at fs use the shadow values, which are exactly what this cycle commits.
  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    ramp_cnt_d  = ramp_cnt_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StDisabled: begin
        if (en_sh_q) state_d = StArmed;
      end
      StArmed: begin
        if (!en_sh_q) begin
          state_d = StDisabled;
        end else if (fs) begin
          state_d     = StRun;
          frame_cnt_d = FCNT_BITS'(1);
          active_d    = auto_sh_q ? 4'd0 : tgt_sh_q;
          ramp_cnt_d  = 8'd0;
        end
      end
      StRun: begin
        if (fs) begin
          if (!en_sh_q) begin
            state_d  = StDisabled;
            active_d = 4'd0;
          end else begin
            frame_cnt_d = frame_cnt_q + FCNT_BITS'(1);
            if (!auto_sh_q) begin
              active_d = tgt_sh_q;
            end else if (ramp_cnt_q >= ivl_m1) begin
              ramp_cnt_d = 8'd0;
              if (active_q < tgt_sh_q) begin
                active_d = active_q + 4'd1;
              end else if (active_q > tgt_sh_q) begin
                active_d = active_q - 4'd1;
              end
            end else begin
              ramp_cnt_d = ramp_cnt_q + 8'd1;
            end
          end
        end
      end
      default: state_d = StDisabled;
    endcase
  end

  // Next-state values give one clock of latency from the qualifying line end.
  always_comb begin
    nr_level_d = 4'd0;
    if ((state_d == StRun) && (line_cnt_d >= EdgeLines)) nr_level_d = active_d;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      en_sh_q     <= 1'b0;
      auto_sh_q   <= 1'b0;
      tgt_sh_q    <= 4'd0;
      ramp_sh_q   <= 8'd0;
      cur_auto_q  <= 1'b0;
      cur_tgt_q   <= 4'd0;
      state_q     <= StDisabled;
      active_q    <= 4'd0;
      ramp_cnt_q  <= 8'd0;
      line_cnt_q  <= '0;
      frame_cnt_q <= '0;
      nr_level_q  <= 4'd0;
      rdata_q     <= 8'd0;
      rvalid_q    <= 1'b0;
    end else begin
      en_sh_q     <= en_sh_d;
      auto_sh_q   <= auto_sh_d;
      tgt_sh_q    <= tgt_sh_d;
      ramp_sh_q   <= ramp_sh_d;
      cur_auto_q  <= cur_auto_d;
      cur_tgt_q   <= cur_tgt_d;
      state_q     <= state_d;
      active_q    <= active_d;
      ramp_cnt_q  <= ramp_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      nr_level_q  <= nr_level_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign nr_level   = nr_level_q;
  assign frame_cnt  = frame_cnt_q;
  assign cfg_rdata  = rdata_q;
  assign cfg_rvalid = rvalid_q;

endmodule

// File: tb/tb_isp_bnr_ctrl.sv
// Directed bench for isp_bnr_ctrl: frame/line sequences with hand-computed nr_level, status and
// register expectations.
module tb_isp_bnr_ctrl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_write = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [7:0]  cfg_wdata = 8'd0;
  logic        cfg_ready;
  logic [7:0]  cfg_rdata;
  logic        cfg_rvalid;
  logic        in_href = 1'b0;
  logic        in_vsync = 1'b0;
  logic [3:0]  nr_level;
  logic        ramp_busy;
  logic [15:0] frame_cnt;

  int checks = 0;
  int failures = 0;

  isp_bnr_ctrl #(
    .EDGE_LINES (2),
    .MAX_LEVEL  (4),
    .FCNT_BITS  (16)
  ) dut (
    .pclk       (pclk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_write  (cfg_write),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_ready  (cfg_ready),
    .cfg_rdata  (cfg_rdata),
    .cfg_rvalid (cfg_rvalid),
    .in_href    (in_href),
    .in_vsync   (in_vsync),
    .nr_level   (nr_level),
    .ramp_busy  (ramp_busy),
    .frame_cnt  (frame_cnt)
  );

  always #5 pclk = ~pclk;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cfg_valid = 1'b0;
    in_href = 1'b0;
    in_vsync = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    #1;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    if (!cfg_ready) begin
      checks++;
      failures++;
      $display("FAIL %s: cfg_ready stuck low, got %0b want 1", name, cfg_ready);
    end
  endtask

  task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
    cfg_valid = 1'b1;
    cfg_write = 1'b1;
    cfg_addr  = addr;
    cfg_wdata = data;
    wait_ready("write_ready");
    tick();
    cfg_valid = 1'b0;
    cfg_write = 1'b0;
  endtask

  task automatic reg_read(input logic [1:0] addr, output logic [7:0] data, output logic rv);
    cfg_valid = 1'b1;
    cfg_write = 1'b0;
    cfg_addr  = addr;
    wait_ready("read_ready");
    tick();
    cfg_valid = 1'b0;
    data = cfg_rdata;
    rv   = cfg_rvalid;
  endtask

  task automatic fs_pulse();
    in_vsync = 1'b1;
    tick();
    tick();
    in_vsync = 1'b0;
    tick();
  endtask

  task automatic do_line();
    in_href = 1'b1;
    repeat (4) tick();
    in_href = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    if (nr_level !== 4'd0) begin
      failures++; $display("FAIL reset_nr_level: got %0d want 0", nr_level);
    end
    checks++;
    if (frame_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL reset_cfg_ready: got %0b want 1", cfg_ready);
    end
    checks++;
    if ({cfg_rvalid, ramp_busy, cfg_rdata} !== 10'd0) begin
      failures++; $display("FAIL reset_misc: got %h want 0", {cfg_rvalid, ramp_busy, cfg_rdata});
    end
    checks++;
  endtask

  task automatic test_manual();
    logic [7:0] d;
    logic       rv;
    apply_reset();
    reg_write(2'd1, 8'd3);
    reg_write(2'd0, 8'h01);
    tick();
    do_line();
    do_line();
    if (nr_level !== 4'd0) begin
      failures++; $display("FAIL manual_prefs: got %0d want 0", nr_level);
    end
    checks++;
    for (int f = 1; f <= 3; f++) begin
      fs_pulse();
      if (nr_level !== 4'd0 || frame_cnt !== 16'(f)) begin
        failures++;
        $display("FAIL manual_fs f%0d: nr %0d fc %0d want 0 %0d", f, nr_level, frame_cnt, f);
      end
      checks++;
      do_line();
      in_href = 1'b1;
      repeat (4) tick();
      in_href = 1'b0;
      #1;
      if (nr_level !== 4'd0) begin
        failures++; $display("FAIL manual_edge f%0d: got %0d want 0", f, nr_level);
      end
      checks++;
      tick();
      if (nr_level !== 4'd3) begin
        failures++; $display("FAIL manual_latency f%0d: got %0d want 3", f, nr_level);
      end
      checks++;
      tick();
      repeat (4) do_line();
      if (nr_level !== 4'd3) begin
        failures++; $display("FAIL manual_body f%0d: got %0d want 3", f, nr_level);
      end
      checks++;
    end
    reg_read(2'd3, d, rv);
    if (d !== 8'h23 || rv !== 1'b1) begin
      failures++; $display("FAIL manual_status: got %h rv %0b want 23 rv 1", d, rv);
    end
    checks++;
    tick();
    if (cfg_rvalid !== 1'b0 || cfg_rdata !== 8'h23) begin
      failures++; $display("FAIL manual_rhold: rv %0b d %h want 0 23", cfg_rvalid, cfg_rdata);
    end
    checks++;
  endtask

  task automatic test_auto_ramp();
    logic [3:0] exp_lvl [9];
    exp_lvl = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4};
    apply_reset();
    reg_write(2'd2, 8'd2);
    reg_write(2'd1, 8'd4);
    reg_write(2'd0, 8'h03);
    tick();
    for (int i = 0; i < 9; i++) begin
      fs_pulse();
      do_line();
      do_line();
      if (nr_level !== exp_lvl[i] || frame_cnt !== 16'(i + 1)) begin
        failures++;
        $display("FAIL auto_level f%0d: nr %0d fc %0d want %0d %0d", i, nr_level, frame_cnt,
                 exp_lvl[i], i + 1);
      end
      checks++;
      if (ramp_busy !== (i < 8)) begin
        failures++; $display("FAIL auto_busy f%0d: got %0b want %0b", i, ramp_busy, i < 8);
      end
      checks++;
    end
  endtask

  task automatic test_collision();
    apply_reset();
    reg_write(2'd1, 8'd3);
    reg_write(2'd0, 8'h01);
    tick();
    fs_pulse();
    do_line();
    do_line();
    cfg_valid = 1'b1;
    cfg_write = 1'b1;
    cfg_addr  = 2'd1;
    cfg_wdata = 8'd1;
    tick();
    in_vsync  = 1'b1;
    cfg_wdata = 8'd2;
    #1;
    if (cfg_ready !== 1'b0) begin
      failures++; $display("FAIL coll_ready_fs: got %0b want 0", cfg_ready);
    end
    checks++;
    tick();
    if (cfg_ready !== 1'b1) begin
      failures++; $display("FAIL coll_ready_after: got %0b want 1", cfg_ready);
    end
    checks++;
    tick();
    cfg_valid = 1'b0;
    cfg_write = 1'b0;
    in_vsync  = 1'b0;
    tick();
    do_line();
    do_line();
    if (nr_level !== 4'd1) begin
      failures++; $display("FAIL coll_frame_lvl: got %0d want 1", nr_level);
    end
    checks++;
    fs_pulse();
    do_line();
    do_line();
    if (nr_level !== 4'd2) begin
      failures++; $display("FAIL coll_next_lvl: got %0d want 2", nr_level);
    end
    checks++;
  endtask

  task automatic test_clamp_disable();
    logic [7:0] d;
    logic       rv;
    apply_reset();
    reg_write(2'd1, 8'd9);
    reg_read(2'd1, d, rv);
    if (d !== 8'd4) begin
      failures++; $display("FAIL clamp_read: got %0d want 4", d);
    end
    checks++;
    reg_write(2'd0, 8'h01);
    tick();
    fs_pulse();
    do_line();
    do_line();
    reg_write(2'd0, 8'h00);
    do_line();
    if (nr_level !== 4'd4) begin
      failures++; $display("FAIL dis_hold: got %0d want 4", nr_level);
    end
    checks++;
    reg_read(2'd3, d, rv);
    if (d !== 8'h24) begin
      failures++; $display("FAIL dis_status_run: got %h want 24", d);
    end
    checks++;
    fs_pulse();
    do_line();
    do_line();
    reg_read(2'd3, d, rv);
    if (nr_level !== 4'd0 || d !== 8'h00) begin
      failures++; $display("FAIL dis_after_fs: nr %0d status %h want 0 00", nr_level, d);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    logic       rv;
    apply_reset();
    reg_write(2'd1, 8'd2);
    reg_write(2'd0, 8'h01);
    tick();
    fs_pulse();
    repeat (3) do_line();
    if (nr_level !== 4'd2) begin
      failures++; $display("FAIL rstmid_pre: got %0d want 2", nr_level);
    end
    checks++;
    rst = 1'b1;
    tick();
    if (nr_level !== 4'd0 || frame_cnt !== 16'd0 || cfg_ready !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_outs: nr %0d fc %0d rdy %0b want 0 0 1", nr_level, frame_cnt, cfg_ready);
    end
    checks++;
    rst = 1'b0;
    tick();
    reg_read(2'd3, d, rv);
    if (d !== 8'h00) begin
      failures++; $display("FAIL rstmid_status: got %h want 00", d);
    end
    checks++;
    fs_pulse();
    do_line();
    do_line();
    if (nr_level !== 4'd0) begin
      failures++; $display("FAIL rstmid_noarm: got %0d want 0", nr_level);
    end
    checks++;
  endtask

  task automatic test_tiebreak();
    apply_reset();
    reg_write(2'd1, 8'd1);
    reg_write(2'd0, 8'h01);
    tick();
    fs_pulse();
    do_line();
    do_line();
    in_href = 1'b1;
    repeat (4) tick();
    in_href  = 1'b0;
    in_vsync = 1'b1;
    tick();
    if (dut.line_cnt_q !== 2'd0 || nr_level !== 4'd0) begin
      failures++;
      $display("FAIL tie_fs_le: line_cnt %0d nr %0d want 0 0", dut.line_cnt_q, nr_level);
    end
    checks++;
    in_vsync = 1'b0;
    tick();
    do_line();
    if (dut.line_cnt_q !== 2'd1 || nr_level !== 4'd0) begin
      failures++;
      $display("FAIL tie_next_line: line_cnt %0d nr %0d want 1 0", dut.line_cnt_q, nr_level);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto_ramp();
    test_collision();
    test_clamp_disable();
    test_reset_mid();
    test_tiebreak();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/isp_bnr_ctrl.md
Name: isp_bnr_ctrl

Overview:
Frame-synchronous controller that sequences the Bayer noise-reduction stage's nr_level input.
- A small register interface (valid/ready) holds enable, mode, target level and ramp interval in shadow registers.
- Shadow values are committed only at frame start (in_vsync rising edge), so the BNR never changes kernel mid-frame.
- In auto mode the active level ramps one step per N frames.
- The first EDGE_LINES lines of every frame are forced to level 0, because the 5x5 window there still spans the previous frame's line-buffer contents.

Parameters:
EDGE_LINES, 2, lines at top of each frame forced to nr_level 0
MAX_LEVEL, 4, highest legal NR level; larger writes are clamped to this
FCNT_BITS, 16, width of frame counter

Ports:
pclk  in  1  pixel clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  register access request
cfg_write  in  1  1=write, 0=read
cfg_addr  in  2  0=CTRL, 1=TARGET, 2=RAMP, 3=STATUS
cfg_wdata  in  8  write data
cfg_ready  out  1  access accepted when cfg_valid&cfg_ready
cfg_rdata  out  8  read data, valid with cfg_rvalid
cfg_rvalid  out  1  one-cycle pulse, 1 clk after accepted read
in_href  in  1  line valid (same signal fed to BNR)
in_vsync  in  1  frame sync, active high
nr_level  out  4  level driven to BNR
ramp_busy  out  1  run state, auto mode, active level != target
frame_cnt  out  FCNT_BITS  frames started since entering RUN, wraps

Behaviour:
- Clock and reset: one clock (pclk). Reset is synchronous and active-high (rst). On rst, all outputs and registers are 0, cfg_ready is 1 and the state is DISABLED.
- Registers:
  - CTRL: [0]=enable, [1]=auto_ramp.
  - TARGET: [3:0] target level, clamped to MAX_LEVEL on write; reads return the clamped value.
  - RAMP: [7:0] interval in frames; 0 behaves as 1.
  - STATUS (read-only): [3:0]=active_level, [5:4]=state, [6]=ramp_busy. Writes to STATUS are accepted and ignored.
- Edge detection: fs = in_vsync & ~vsync_d; le = href_d & ~in_href. vsync_d and href_d are 1-clk registered copies.
- Commit: in the cycle fs is high, shadow registers are copied to the working set.
  - cfg_ready is 0 in that cycle only, so no write can collide with a commit.
  - A write accepted the cycle before fs is included in that commit.
- line_cnt:
  - cleared on fs;
  - incremented on le;
  - saturates at EDGE_LINES.
- FSM (2-bit encoding): DISABLED=0, ARMED=1, RUN=2.
  - DISABLED -> ARMED when the shadow enable becomes 1 (cycle after write).
  - ARMED -> RUN on fs, if the committed enable is 1. frame_cnt is set to 1. active_level is set to the target in manual mode, or 0 in auto mode.
  - ARMED -> DISABLED immediately if the shadow enable is cleared before fs.
  - RUN -> DISABLED on fs when the committed enable is 0. active_level becomes 0.
  - Clearing enable mid-frame has no effect until the next fs.
- Level update in RUN at each fs:
  - frame_cnt increments (wraps).
  - Manual mode: active_level = committed target.
  - Auto mode: ramp_cnt increments. When ramp_cnt reaches interval-1, ramp_cnt clears and active_level moves one step toward target (+1 or -1; no change if equal).
  - A target change mid-ramp retargets from the current level; ramp_cnt is not cleared.
- Output, registered:
  - nr_level = active_level when state==RUN and line_cnt >= EDGE_LINES; otherwise 0.
  - Latency: 1 clk from the le that makes line_cnt reach EDGE_LINES.
  - nr_level returns to 0 on the clk after fs.
- Reads: cfg_ready is 1 except in commit cycles. cfg_rdata is registered and held until the next read.
- Simultaneous fs and le: fs wins; line_cnt becomes 0.
- Reset mid-frame: state DISABLED; nr_level stays 0 until re-armed and the next fs arrives.

Decomposition:
- Shared package isp_bnr_pkg:
  - register address constants (ADDR_CTRL, ADDR_TARGET, ADDR_RAMP, ADDR_STATUS);
  - state encoding;
  - the NR_LEVEL_MAX constant, shared with the BNR datapath.
- One sub-module is natural: isp_sync_edge, the vsync/href edge detector producing fs and le. It is reusable by other ISP controllers.
- Register file, FSM and ramp logic stay in isp_bnr_ctrl.

Test Plan:
- Manual mode:
  - Stimulus: write TARGET=3, CTRL=0x01; run 3 frames of 6 lines, EDGE_LINES=2.
  - Required response: nr_level=0 until the first fs. In each frame, 0 for lines 0-1, then 3 from 1 clk after the 2nd href fall. STATUS reads 0x23.
- Auto ramp:
  - Stimulus: RAMP=2, TARGET=4, CTRL=0x03.
  - Required response: active_level across frames is 0,0,1,1,2,2,3,3,4. ramp_busy drops in the frame where the level reaches 4.
- Commit collision:
  - Stimulus: write TARGET=1 the cycle before fs, then attempt TARGET=2 on the fs cycle.
  - Required response: cfg_ready=0 on the fs cycle; the frame runs at level 1; level 2 is applied at the next fs once the write completes.
- Clamp and disable:
  - Stimulus: write TARGET=9, then read it back. Clear enable mid-frame.
  - Required response: TARGET reads 4. The level is held until the next fs, then nr_level=0 and state=0.
- Reset mid-frame:
  - Stimulus: assert rst at line 3 while nr_level=2.
  - Required response: on the next clk, nr_level=0, frame_cnt=0, cfg_ready=1, STATUS=0.
- Tie-break:
  - Stimulus: drive fs and le in the same cycle.
  - Required response: line_cnt=0 on the following clk.
